// File: rtl/button_event_decoder_pkg.sv
// Shared types and default timing for the button gesture decoder.
// Defaults are derived from the 50 MHz board clock.
package button_event_decoder_pkg;

    localparam int unsigned CLK_HZ                    = 50_000_000;
    localparam int unsigned LONG_PRESS_CYCLES_DEFAULT = CLK_HZ / 2;
    localparam int unsigned DOUBLE_GAP_CYCLES_DEFAULT = CLK_HZ / 4;
    localparam int unsigned COUNT_WIDTH_DEFAULT       = 25;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        LONG_HOLD = 3'd2,
        GAP       = 3'd3,
        PRESS2    = 3'd4
    } state_e;

endpackage

// File: rtl/button_event_decoder_if.sv
// Button level in, gesture events and status out.
// The decoder takes the slave side of this interface.
interface button_event_decoder_if;

    logic i_FILTER_SIGNAL;
    logic o_SINGLE_CLICK;
    logic o_DOUBLE_CLICK;
    logic o_LONG_PRESS;
    logic o_HELD;
    logic o_BUSY;

    modport master (
        output i_FILTER_SIGNAL,
        input  o_SINGLE_CLICK, o_DOUBLE_CLICK, o_LONG_PRESS, o_HELD, o_BUSY
    );

    modport slave (
        input  i_FILTER_SIGNAL,
        output o_SINGLE_CLICK, o_DOUBLE_CLICK, o_LONG_PRESS, o_HELD, o_BUSY
    );

endinterface

// File: rtl/button_edge_detect.sv
// Rise/fall detector for a synchronous button level.
// The previous-level register resets high, so a button held through reset gives no rise.
module button_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button activity into single click, double click and long press.
// Event outputs are one-cycle registered pulses; held/busy are registered levels.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT,
    parameter int unsigned DOUBLE_GAP_CYCLES = DOUBLE_GAP_CYCLES_DEFAULT,
    parameter int unsigned COUNT_WIDTH       = COUNT_WIDTH_DEFAULT
) (
    input  logic                  i_CLOCK_SOURCE,
    input  logic                  i_RESET,
    button_event_decoder_if.slave bus
);

    localparam logic [COUNT_WIDTH-1:0] LONG_LAST = COUNT_WIDTH'(LONG_PRESS_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] GAP_LAST  = COUNT_WIDTH'(DOUBLE_GAP_CYCLES - 1);

    logic rise;
    logic fall;

    state_e                 state_q,  state_d;
    logic [COUNT_WIDTH-1:0] count_q,  count_d;
    logic                   single_q, single_d;
    logic                   double_q, double_d;
    logic                   long_q,   long_d;
    logic                   held_q,   held_d;
    logic                   busy_q,   busy_d;

    button_edge_detect u_edge (
        .clk   (i_CLOCK_SOURCE),
        .rst   (i_RESET),
        .level (bus.i_FILTER_SIGNAL),
        .rise  (rise),
        .fall  (fall)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q + 1'b1;
        single_d = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (rise) state_d = PRESS1;
            end
            PRESS1, PRESS2: begin
                // Release takes priority over reaching the long-press threshold.
                if (fall) begin
                    count_d = '0;
                    if (state_q == PRESS2) begin
                        double_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end else if (count_q == LONG_LAST) begin
                    count_d = '0;
                    long_d  = 1'b1;
                    state_d = LONG_HOLD;
                end
            end
            LONG_HOLD: begin
                count_d = '0;
                if (fall) state_d = IDLE;
            end
            GAP: begin
                // A second press on the timeout edge still counts as a double click.
                if (rise) begin
                    count_d = '0;
                    state_d = PRESS2;
                end else if (count_q == GAP_LAST) begin
                    count_d  = '0;
                    single_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase
        held_d = (state_d == LONG_HOLD);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_CLOCK_SOURCE) begin
        if (i_RESET) begin
            state_q  <= IDLE;
            count_q  <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            held_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            single_q <= single_d;
            double_q <= double_d;
            long_q   <= long_d;
            held_q   <= held_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.o_SINGLE_CLICK = single_q;
    assign bus.o_DOUBLE_CLICK = double_q;
    assign bus.o_LONG_PRESS   = long_q;
    assign bus.o_HELD         = held_q;
    assign bus.o_BUSY         = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed gestures plus random press/release runs,
// compared every cycle against a timestamp-based gesture model.
module tb_button_event_decoder;

    localparam int unsigned L = 8;
    localparam int unsigned G = 6;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    button_event_decoder_if bus ();

    button_event_decoder #(
        .LONG_PRESS_CYCLES (L),
        .DOUBLE_GAP_CYCLES (G),
        .COUNT_WIDTH       (W)
    ) dut (
        .i_CLOCK_SOURCE (clk),
        .i_RESET        (rst),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Gesture model: tracks presses within a gesture and the time of the last edge.
    bit     m_prev    = 1'b1;
    bit     m_active  = 1'b0;
    bit     m_down    = 1'b0;
    bit     m_long    = 1'b0;
    int     m_presses = 0;
    longint m_now     = 0;
    longint m_mark    = 0;
    bit     e_single, e_double, e_long, e_held, e_busy;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (time %0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit in, input bit r);
        bit rise, fall;
        m_now++;
        e_single = 1'b0;
        e_double = 1'b0;
        e_long   = 1'b0;
        if (r) begin
            m_prev   = 1'b1;
            m_active = 1'b0;
        end else begin
            rise   = in && !m_prev;
            fall   = !in && m_prev;
            m_prev = in;
            if (!m_active) begin
                if (rise) begin
                    m_active = 1'b1; m_down = 1'b1; m_long = 1'b0;
                    m_presses = 1; m_mark = m_now;
                end
            end else if (m_long) begin
                if (fall) m_active = 1'b0;
            end else if (m_down) begin
                if (fall) begin
                    if (m_presses == 2) begin
                        e_double = 1'b1; m_active = 1'b0;
                    end else begin
                        m_down = 1'b0; m_mark = m_now;
                    end
                end else if (m_now - m_mark == longint'(L)) begin
                    e_long = 1'b1; m_long = 1'b1;
                end
            end else begin
                if (rise) begin
                    m_presses = 2; m_down = 1'b1; m_mark = m_now;
                end else if (m_now - m_mark == longint'(G)) begin
                    e_single = 1'b1; m_active = 1'b0;
                end
            end
        end
        e_held = m_active && m_long;
        e_busy = m_active;
    endtask

    task automatic cycle(input bit in, input bit r);
        bus.i_FILTER_SIGNAL = in;
        rst = r;
        model_step(in, r);
        @(posedge clk);
        @(negedge clk);
        check_eq("single", bus.o_SINGLE_CLICK, e_single);
        check_eq("double", bus.o_DOUBLE_CLICK, e_double);
        check_eq("long",   bus.o_LONG_PRESS,   e_long);
        check_eq("held",   bus.o_HELD,         e_held);
        check_eq("busy",   bus.o_BUSY,         e_busy);
    endtask

    task automatic run(input bit lvl, input int n, input bit r);
        repeat (n) cycle(lvl, r);
    endtask

    initial begin
        bus.i_FILTER_SIGNAL = 1'b0;
        run(1'b0, 3, 1'b1);
        run(1'b0, 4, 1'b0);

        // single click
        run(1'b1, 3, 1'b0); run(1'b0, 10, 1'b0);
        // double click
        run(1'b1, 3, 1'b0); run(1'b0, 2, 1'b0); run(1'b1, 3, 1'b0); run(1'b0, 10, 1'b0);
        // long press held well past threshold
        run(1'b1, 20, 1'b0); run(1'b0, 10, 1'b0);
        // second press arrives on the gap timeout edge
        run(1'b1, 3, 1'b0); run(1'b0, G, 1'b0); run(1'b1, 3, 1'b0); run(1'b0, 10, 1'b0);
        // release on the long-press threshold edge
        run(1'b1, L, 1'b0); run(1'b0, 10, 1'b0);
        // gap one cycle short of and one past the timeout
        run(1'b1, 2, 1'b0); run(1'b0, G - 1, 1'b0); run(1'b1, 2, 1'b0); run(1'b0, 10, 1'b0);
        run(1'b1, 2, 1'b0); run(1'b0, G + 1, 1'b0); run(1'b1, 2, 1'b0); run(1'b0, 10, 1'b0);
        // long press during the second press
        run(1'b1, 2, 1'b0); run(1'b0, 2, 1'b0); run(1'b1, 12, 1'b0); run(1'b0, 10, 1'b0);
        // button held through reset, then a fresh press
        run(1'b1, 3, 1'b1); run(1'b1, 4, 1'b0); run(1'b0, 10, 1'b0);
        run(1'b1, 3, 1'b0); run(1'b0, 10, 1'b0);
        // reset in the middle of the second press
        run(1'b1, 3, 1'b0); run(1'b0, 2, 1'b0); run(1'b1, 2, 1'b0);
        run(1'b1, 1, 1'b1); run(1'b0, 10, 1'b0);

        begin
            bit lvl;
            lvl = 1'b0;
            for (int i = 0; i < 400; i++) begin
                int n;
                lvl = ~lvl;
                n = int'($urandom_range(1, 12));
                for (int j = 0; j < n; j++) begin
                    cycle(lvl, ($urandom_range(0, 149) == 0));
                end
            end
        end
        run(1'b0, 15, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
